// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: op codes, FSM states and the
// multiply/divide mode select.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_XOR = 4'd3,
    OP_SLL = 4'd4,
    OP_SRL = 4'd5,
    OP_SLE = 4'd6,
    OP_MUL = 4'd7,
    OP_OR  = 4'd8,
    OP_SRA = 4'd9,
    OP_SLT = 4'd10,
    OP_DIV = 4'd11
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  typedef enum logic {
    MD_MUL = 1'b0,
    MD_DIV = 1'b1
  } md_mode_e;

  function automatic logic is_multicycle(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per
// cycle. lo/hi present the result of the step being taken this cycle.
module muldiv_iter
  import alu_pkg::*;
#(
  parameter int DSIZE = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [DSIZE-1:0] a,
  input  logic [DSIZE-1:0] b,
  output logic             done,
  output logic [DSIZE-1:0] lo,
  output logic [DSIZE-1:0] hi
);

  localparam int CW = $clog2(DSIZE);

  logic             r_busy;
  md_mode_e         r_mode;
  logic [CW-1:0]    r_cnt;
  logic [DSIZE-1:0] r_acc;
  logic [DSIZE-1:0] r_sr;
  logic [DSIZE-1:0] r_opb;

  logic [DSIZE:0]   w_sum;
  logic [DSIZE:0]   w_shl;
  logic [DSIZE:0]   w_dif;
  logic [DSIZE-1:0] w_acc_nx;
  logic [DSIZE-1:0] w_sr_nx;

  // A zero divisor never borrows, so the quotient fills with ones and the
  // remainder ends up holding the dividend without any special casing.
  always_comb begin
    w_sum = {1'b0, r_acc} + (r_sr[0] ? {1'b0, r_opb} : '0);
    w_shl = {r_acc, r_sr[DSIZE-1]};
    w_dif = w_shl - {1'b0, r_opb};
    if (r_mode == MD_MUL) begin
      w_acc_nx = w_sum[DSIZE:1];
      w_sr_nx  = {w_sum[0], r_sr[DSIZE-1:1]};
    end else if (!w_dif[DSIZE]) begin
      w_acc_nx = w_dif[DSIZE-1:0];
      w_sr_nx  = {r_sr[DSIZE-2:0], 1'b1};
    end else begin
      w_acc_nx = w_shl[DSIZE-1:0];
      w_sr_nx  = {r_sr[DSIZE-2:0], 1'b0};
    end
  end

  assign done = r_busy && (r_cnt == CW'(DSIZE - 1));
  assign lo   = w_sr_nx;
  assign hi   = w_acc_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_mode <= MD_MUL;
      r_cnt  <= '0;
      r_acc  <= '0;
      r_sr   <= '0;
      r_opb  <= '0;
    end else if (start) begin
      r_busy <= 1'b1;
      r_mode <= md_mode_e'(mode);
      r_cnt  <= '0;
      r_acc  <= '0;
      r_sr   <= a;
      r_opb  <= b;
    end else if (r_busy) begin
      r_acc <= w_acc_nx;
      r_sr  <= w_sr_nx;
      if (done) begin
        r_busy <= 1'b0;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked EX-stage ALU: registered single-cycle ops plus a fixed-latency
// iterative multiply/divide unit, with zero/overflow/divide-by-zero flags.
module alu_seq
  import alu_pkg::*;
#(
  parameter int DSIZE = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [DSIZE-1:0] a,
  input  logic [DSIZE-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DSIZE-1:0] out,
  output logic [DSIZE-1:0] hi,
  output logic             zero,
  output logic             ovf,
  output logic             dz
);

  localparam int SHW = $clog2(DSIZE);
  localparam int MSB = DSIZE - 1;

  state_e           r_state;
  state_e           w_next;
  logic [DSIZE-1:0] r_out;
  logic [DSIZE-1:0] r_hi;
  logic             r_zero;
  logic             r_ovf;
  logic             r_dz;
  logic             r_dz_pend;

  op_e              w_op;
  logic             w_accept;
  logic             w_mc;
  logic             w_start;
  logic [SHW-1:0]   w_sh;
  logic [DSIZE-1:0] w_sum;
  logic [DSIZE-1:0] w_dif;
  logic [DSIZE-1:0] w_res;
  logic             w_ovf;
  logic             w_md_done;
  logic [DSIZE-1:0] w_md_lo;
  logic [DSIZE-1:0] w_md_hi;

  assign w_op = op_e'(op);
  assign w_sh = b[SHW-1:0];

  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    w_sum = a + b;
    w_dif = a - b;
    case (w_op)
      OP_ADD: begin
        w_res = w_sum;
        w_ovf = (a[MSB] == b[MSB]) && (w_sum[MSB] != a[MSB]);
      end
      OP_SUB: begin
        w_res = w_dif;
        w_ovf = (a[MSB] != b[MSB]) && (w_dif[MSB] != a[MSB]);
      end
      OP_AND:  w_res = a & b;
      OP_OR:   w_res = a | b;
      OP_XOR:  w_res = a ^ b;
      OP_SLL:  w_res = a << w_sh;
      OP_SRL:  w_res = a >> w_sh;
      OP_SRA:  w_res = $signed(a) >>> w_sh;
      OP_SLE:  w_res = {{(DSIZE-1){1'b0}}, (a <= b)};
      OP_SLT:  w_res = {{(DSIZE-1){1'b0}}, ($signed(a) < $signed(b))};
      default: w_res = '0;
    endcase
  end

  always_comb begin
    in_ready = (r_state == IDLE) || ((r_state == DONE) && out_ready);
    w_accept = in_valid && in_ready;
    w_mc     = is_multicycle(op);
    w_start  = w_accept && w_mc;
    w_next   = r_state;
    case (r_state)
      IDLE: if (w_accept) w_next = w_mc ? BUSY : DONE;
      BUSY: if (w_md_done) w_next = DONE;
      DONE: begin
        if (w_accept)       w_next = w_mc ? BUSY : DONE;
        else if (out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  muldiv_iter #(
    .DSIZE(DSIZE)
  ) u_muldiv (
    .clk  (clk),
    .rst  (rst),
    .start(w_start),
    .mode (w_op == OP_DIV),
    .a    (a),
    .b    (b),
    .done (w_md_done),
    .lo   (w_md_lo),
    .hi   (w_md_hi)
  );

  // Result registers only move on a 1-cycle accept or the final iteration,
  // so a stalled DONE result stays put while out_ready is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_out     <= '0;
      r_hi      <= '0;
      r_zero    <= 1'b0;
      r_ovf     <= 1'b0;
      r_dz      <= 1'b0;
      r_dz_pend <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept && !w_mc) begin
        r_out  <= w_res;
        r_hi   <= '0;
        r_zero <= (w_res == '0);
        r_ovf  <= w_ovf;
        r_dz   <= 1'b0;
      end else if (w_start) begin
        r_dz_pend <= (w_op == OP_DIV) && (b == '0);
      end else if ((r_state == BUSY) && w_md_done) begin
        r_out  <= w_md_lo;
        r_hi   <= w_md_hi;
        r_zero <= (w_md_lo == '0);
        r_ovf  <= 1'b0;
        r_dz   <= r_dz_pend;
      end
    end
  end

  assign out_valid = (r_state == DONE);
  assign out       = r_out;
  assign hi        = r_hi;
  assign zero      = r_zero;
  assign ovf       = r_ovf;
  assign dz        = r_dz;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (DSIZE=16): directed vectors push expected
// results; a monitor pops and compares whenever a result is consumed.
module tb_alu_seq;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out;
  logic [15:0] hi;
  logic        zero;
  logic        ovf;
  logic        dz;

  alu_seq #(
    .DSIZE(16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out      (out),
    .hi       (hi),
    .zero     (zero),
    .ovf      (ovf),
    .dz       (dz)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] out;
    logic [15:0] hi;
    logic        zero;
    logic        ovf;
    logic        dz;
    int          acc_cyc;
    int          lat;
    int          id;
  } exp_t;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] eo;
    logic [15:0] eh;
    logic        eov;
    logic        edz;
    int          lat;
  } vec_t;

  exp_t q[$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  bit   seen = 1'b0;
  int   first_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Monitor: samples mid-cycle, checks stalls while an op is in flight and
  // compares each result on the cycle it is consumed.
  always begin
    exp_t e;
    @(negedge clk);
    #2;
    if (!rst) begin
      if (q.size() > 0 && cyc > q[0].acc_cyc && !out_valid)
        chk($sformatf("busy_in_ready v%0d", q[0].id), 64'(in_ready), 64'(0));
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("spurious_out_valid", 64'(out_valid), 64'(0));
        end else begin
          if (!seen) begin
            seen = 1'b1;
            first_cyc = cyc;
          end
          if (out_ready) begin
            e = q.pop_front();
            seen = 1'b0;
            chk($sformatf("out v%0d", e.id), 64'(out), 64'(e.out));
            chk($sformatf("hi v%0d", e.id), 64'(hi), 64'(e.hi));
            chk($sformatf("flags(z,ovf,dz) v%0d", e.id), 64'({zero, ovf, dz}),
                64'({e.zero, e.ovf, e.dz}));
            chk($sformatf("latency v%0d", e.id), 64'(first_cyc - e.acc_cyc), 64'(e.lat));
          end
        end
      end
    end
  end

  task automatic issue(input logic [3:0] o, input logic [15:0] xa, input logic [15:0] xb,
                       input logic [15:0] eo, input logic [15:0] eh, input logic eov,
                       input logic edz, input int lat, input int id);
    int   guard;
    exp_t e;
    guard = 0;
    @(negedge clk);
    op = o;
    a = xa;
    b = xb;
    in_valid = 1'b1;
    #1;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (!in_ready) begin
      chk($sformatf("issue_timeout v%0d", id), 64'(in_ready), 64'(1));
      in_valid = 1'b0;
      return;
    end
    e.out = eo;
    e.hi = eh;
    e.zero = (eo == 16'h0000);
    e.ovf = eov;
    e.dz = edz;
    e.acc_cyc = cyc;
    e.lat = lat;
    e.id = id;
    q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (q.size() > 0 && n < budget) begin
      @(negedge clk);
      #3;
      n++;
    end
    if (q.size() > 0) begin
      chk("drain_timeout", 64'(q.size()), 64'(0));
      q.delete();
      seen = 1'b0;
    end
  endtask

  vec_t vt[15];
  int   s_first;
  int   s_last;

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vt = '{
      '{OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 16'h0000, 1'b1, 1'b0, 1},
      '{OP_SUB, 16'h0005, 16'h0005, 16'h0000, 16'h0000, 1'b0, 1'b0, 1},
      '{OP_SRA, 16'h8000, 16'h0004, 16'hF800, 16'h0000, 1'b0, 1'b0, 1},
      '{OP_SLT, 16'hFFFF, 16'h0001, 16'h0001, 16'h0000, 1'b0, 1'b0, 1},
      '{OP_SLE, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 1'b0, 1'b0, 1},
      '{OP_SLE, 16'h0001, 16'h0001, 16'h0001, 16'h0000, 1'b0, 1'b0, 1},
      '{OP_SUB, 16'h8000, 16'h0001, 16'h7FFF, 16'h0000, 1'b1, 1'b0, 1},
      '{OP_SLL, 16'h0001, 16'h0013, 16'h0008, 16'h0000, 1'b0, 1'b0, 1},
      '{OP_SRL, 16'h8000, 16'h000F, 16'h0001, 16'h0000, 1'b0, 1'b0, 1},
      '{OP_AND, 16'hF0F0, 16'hFF00, 16'hF000, 16'h0000, 1'b0, 1'b0, 1},
      '{OP_OR,  16'hF0F0, 16'h0F0F, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1},
      '{OP_XOR, 16'hAAAA, 16'hFFFF, 16'h5555, 16'h0000, 1'b0, 1'b0, 1},
      '{4'hC,   16'h1234, 16'h5678, 16'h0000, 16'h0000, 1'b0, 1'b0, 1},
      '{OP_DIV, 16'd100,  16'd7,    16'd14,   16'd2,    1'b0, 1'b0, 17},
      '{OP_DIV, 16'd1234, 16'd0,    16'hFFFF, 16'd1234, 1'b0, 1'b1, 17}
    };

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    op = '0;
    a = '0;
    b = '0;
    repeat (3) @(negedge clk);
    #3;
    chk("reset out_valid", 64'(out_valid), 64'(0));
    chk("reset in_ready", 64'(in_ready), 64'(1));
    chk("reset out/hi", 64'({out, hi}), 64'(0));
    chk("reset flags", 64'({zero, ovf, dz}), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    // MUL with operands scrambled while busy
    issue(OP_MUL, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b0, 1'b0, 17, 100);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      a = 16'($urandom);
      b = 16'($urandom);
    end
    drain(40);

    for (int i = 0; i < 15; i++)
      issue(vt[i].op, vt[i].a, vt[i].b, vt[i].eo, vt[i].eh, vt[i].eov, vt[i].edz, vt[i].lat, i);
    drain(40);

    // Reset in the middle of a MUL; outputs still hold the DIV-by-zero result
    issue(OP_MUL, 16'h1234, 16'h0002, 16'h2468, 16'h0000, 1'b0, 1'b0, 17, 200);
    repeat (5) @(negedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("midrst out_valid", 64'(out_valid), 64'(0));
    chk("midrst out/hi", 64'({out, hi}), 64'(0));
    chk("midrst flags", 64'({zero, ovf, dz}), 64'(0));
    chk("midrst in_ready", 64'(in_ready), 64'(1));
    q.delete();
    seen = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("postrst in_ready", 64'(in_ready), 64'(1));
    issue(OP_ADD, 16'd1, 16'd2, 16'd3, 16'h0000, 1'b0, 1'b0, 1, 201);
    drain(10);

    // Backpressure: result must hold for 5 stalled cycles
    issue(OP_ADD, 16'h0010, 16'h0020, 16'h0030, 16'h0000, 1'b0, 1'b0, 1, 300);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #3;
      chk($sformatf("bp out_valid c%0d", i), 64'(out_valid), 64'(1));
      chk($sformatf("bp out c%0d", i), 64'(out), 64'(16'h0030));
      chk($sformatf("bp in_ready c%0d", i), 64'(in_ready), 64'(0));
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    issue(OP_ADD, 16'd2, 16'd3, 16'd5, 16'h0000, 1'b0, 1'b0, 1, 301);
    drain(10);

    // Back-to-back stream
    s_first = 0;
    s_last = 0;
    for (int i = 0; i < 8; i++) begin
      issue(OP_ADD, 16'(i), 16'h0100, 16'(16'h0100 + i), 16'h0000, 1'b0, 1'b0, 1, 400 + i);
      if (i == 0) s_first = q[q.size() - 1].acc_cyc;
      s_last = q[q.size() - 1].acc_cyc;
    end
    chk("stream accept span", 64'(s_last - s_first), 64'(7));
    drain(20);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
